matrix_encoder_ctrl: RTL

- Sequences the matrix encoder over a 64-line, 25-bit line memory.
- On `start`, reads each line in turn and applies a programmable number of 5×5 lane-permutation rounds to it. It then writes the result back through a ready-gated write port and pulses `done`.
- Sits between the line memory (synchronous read) and the output writer. It owns the address counter, round counter, line register and control FSM.

---
 rtl/encoder_pkg.sv | 28 ++
 rtl/pi_permute.sv | 14 +
 rtl/matrix_encoder_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared constants, FSM state type and pi lane routing
// for the matrix encoder controller.
package encoder_pkg;

  localparam int W     = 25;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int RW    = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_PERM  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Lane i = 5y+x moves to x'=y, y'=(2x+3y) mod 5.
  function automatic int pi_dest(input int i);
    int x;
    int y;
    x = i % 5;
    y = i / 5;
    return 5 * ((2 * x + 3 * y) % 5) + y;
  endfunction

endpackage

// File: rtl/pi_permute.sv
// Combinational 5x5 lane permutation; pure wiring.
// Routing comes from encoder_pkg::pi_dest.
module pi_permute
  import encoder_pkg::*;
(
  input  logic [W-1:0] line_i,
  output logic [W-1:0] line_o
);

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign line_o[pi_dest(i)] = line_i[i];
  end

endmodule

// File: rtl/matrix_encoder_ctrl.sv
// Walks the line memory, applies cfg_rounds pi rounds per
// line and writes each result back through a ready port.
module matrix_encoder_ctrl
  import encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [RW-1:0] cfg_rounds,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data,
  input  logic          wr_ready
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rounds_q, rounds_d;
  logic [W-1:0]  line_q, line_d;
  logic [W-1:0]  line_pi;

  pi_permute u_pi (
    .line_i (line_q),
    .line_o (line_pi)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rounds_d = rounds_q;
    line_d   = line_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rounds_d = cfg_rounds;
          addr_d   = '0;
          state_d  = S_READ;
        end
      end
      S_READ: state_d = S_LOAD;
      S_LOAD: begin
        line_d  = rd_data;
        cnt_d   = rounds_q;
        state_d = (rounds_q != '0) ? S_PERM : S_WRITE;
      end
      S_PERM: begin
        line_d = line_pi;
        cnt_d  = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (addr_q == AW'(DEPTH - 1)) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = S_READ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rounds_q <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rounds_q <= rounds_d;
      line_q   <= line_d;
    end
  end

  // Outputs decode from registered state only.
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign rd_en   = (state_q == S_READ);
  assign wr_en   = (state_q == S_WRITE);
  assign rd_addr = addr_q;
  assign wr_addr = addr_q;
  assign wr_data = line_q;

endmodule
